uart_ram_addr_seq: RTL and testbench

Parametrised RAM address sequencer for the UART↔RAM data path, sitting between the top-level control FSM, the UART rx/tx cores and the single-port buffer RAM. It fills RAM from received bytes or drains RAM to the transmitter. Address width, length width and start address are configurable, and the block adds abort, a zero-length case and an explicit tx handshake. One `done` pulse marks completion of each transfer.

---
 rtl/uart_ram_addr_seq.sv | 142 ++++++++++++++
 tb/tb_uart_ram_addr_seq.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ram_addr_seq.sv
// uart_ram_addr_seq: RAM address sequencer for the UART<->RAM data path.
// Fills the buffer RAM from received bytes, or drains it to the transmitter.
// A single done pulse marks the normal end of each transfer.
// An abort returns the block to IDLE without a done pulse.
module uart_ram_addr_seq #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_wr,
  input  logic              start_rd,
  input  logic              abort,
  input  logic [LEN_W-1:0]  length,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              rx_flag,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              tx_trig,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  xfer_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ADDR,
    S_RD_TRIG,
    S_RD_ACK,
    S_RD_WAIT
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ZERO = '0;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_len;
  logic              r_done;
  logic              r_tx_trig;

  logic              w_start;
  logic              w_last;
  logic              w_wr_byte;
  logic [LEN_W-1:0]  w_len_m1;

  // Decode helpers: any start request, last-byte detection and the gated write strobe
  always_comb begin
    w_start   = start_wr | start_rd;
    w_len_m1  = r_len - LEN_ONE;
    w_last    = (r_cnt == w_len_m1);
    w_wr_byte = (r_state == S_WR) & rx_flag & ~abort;
  end

  // Transfer state machine; tx_trig is registered out of RD_TRIG so the RAM
  // read data has already been valid for a full cycle when the trigger fires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_done    <= 1'b0;
      r_tx_trig <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_tx_trig <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_addr <= base_addr;
              r_cnt  <= '0;
              r_len  <= length;
              if (length == LEN_ZERO) begin
                r_done <= 1'b1;
              end else if (start_wr) begin
                r_state <= S_WR;
              end else begin
                r_state <= S_RD_ADDR;
              end
            end
          end
          S_WR: begin
            if (rx_flag) begin
              r_addr <= r_addr + ADDR_ONE;
              r_cnt  <= r_cnt + LEN_ONE;
              if (w_last) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end
            end
          end
          S_RD_ADDR: begin
            r_state <= S_RD_TRIG;
          end
          S_RD_TRIG: begin
            r_tx_trig <= 1'b1;
            r_state   <= S_RD_ACK;
          end
          S_RD_ACK: begin
            if (tx_busy) begin
              r_state <= S_RD_WAIT;
            end
          end
          S_RD_WAIT: begin
            if (!tx_busy) begin
              r_cnt <= r_cnt + LEN_ONE;
              if (w_last) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end else begin
                r_addr  <= r_addr + ADDR_ONE;
                r_state <= S_RD_ADDR;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Output mapping: the write strobe follows rx_flag combinationally, all else is registered
  always_comb begin
    ram_addr = r_addr;
    ram_we   = w_wr_byte;
    tx_trig  = r_tx_trig;
    busy     = (r_state != S_IDLE);
    done     = r_done;
    xfer_cnt = r_cnt;
  end

endmodule

// File: tb/tb_uart_ram_addr_seq.sv
// tb_uart_ram_addr_seq: scoreboard bench for uart_ram_addr_seq.
// Stimulus pushes the expected write/trigger/done events of each transfer into a queue;
// an independent monitor pops and compares every event the DUT presents.
module tb_uart_ram_addr_seq;

  localparam int EV_WE   = 0;
  localparam int EV_TRIG = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int kind;
    int val;
  } expEv_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_wr;
  logic       start_rd;
  logic       abort;
  logic [7:0] length;
  logic [7:0] base_addr;
  logic       rx_flag;
  logic       tx_busy;
  logic [7:0] ram_addr;
  logic       ram_we;
  logic       tx_trig;
  logic       busy;
  logic       done;
  logic [7:0] xfer_cnt;

  expEv_t expQ[$];
  int     nChecks = 0;
  int     nFails = 0;
  int     cyc = 0;
  int     changeCyc = 0;
  logic [7:0] prevAddr = 8'h00;
  logic   prevBusy = 1'b0;
  int     txBusyCycles = 10;

  uart_ram_addr_seq #(.ADDR_W(8), .LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_wr  (start_wr),
    .start_rd  (start_rd),
    .abort     (abort),
    .length    (length),
    .base_addr (base_addr),
    .rx_flag   (rx_flag),
    .tx_busy   (tx_busy),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .tx_trig   (tx_trig),
    .busy      (busy),
    .done      (done),
    .xfer_cnt  (xfer_cnt)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushEv(input int kind, input int val);
    expEv_t e;
    e.kind = kind;
    e.val  = val;
    expQ.push_back(e);
  endtask

  // Reference model: a transfer of len bytes from base produces one event per byte at
  // consecutive addresses (mod 256), followed by a done reporting len bytes
  task automatic pushXfer(input logic isWrite, input logic [7:0] base, input logic [7:0] len);
    for (int i = 0; i < int'(len); i++) begin
      pushEv(isWrite ? EV_WE : EV_TRIG, (int'(base) + i) % 256);
    end
    pushEv(EV_DONE, int'(len));
  endtask

  task automatic popCheck(input int kind, input int val, input string name);
    expEv_t e;
    nChecks++;
    if (expQ.size() == 0) begin
      nFails++;
      $display("[TB] FAIL %s: unexpected event kind %0d value %0h, scoreboard empty", name, kind, val);
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind || e.val != val) begin
        nFails++;
        $display("[TB] FAIL %s: got kind %0d value %0h, expected kind %0d value %0h",
                 name, kind, val, e.kind, e.val);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every presented event and checks trigger latency
  always @(negedge clk) begin
    cyc++;
    if (ram_addr != prevAddr || (busy && !prevBusy)) changeCyc = cyc;
    prevAddr = ram_addr;
    prevBusy = busy;
    if (ram_we) popCheck(EV_WE, int'(ram_addr), "write event");
    if (tx_trig) begin
      popCheck(EV_TRIG, int'(ram_addr), "trigger event");
      checkOutput("trigger latency", 32'(cyc - changeCyc), 32'd2);
    end
    if (done) begin
      popCheck(EV_DONE, int'(xfer_cnt), "done event");
      checkOutput("busy at done", {31'd0, busy}, 32'd0);
      checkOutput("done exclusive", {30'd0, ram_we, tx_trig}, 32'd0);
    end
  end

  // Transmitter model: goes busy for txBusyCycles after each trigger
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_trig) begin
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (txBusyCycles) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Issue a start (called at posedge+1), check the acceptance cycle, end at the negedge
  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] base, input logic [7:0] len);
    start_wr  = wr;
    start_rd  = rd;
    base_addr = base;
    length    = len;
    @(posedge clk); #1;
    start_wr = 1'b0;
    start_rd = 1'b0;
    @(negedge clk);
    if (len == 8'd0) begin
      checkOutput("zero-length done", {31'd0, done}, 32'd1);
      checkOutput("zero-length busy", {31'd0, busy}, 32'd0);
    end else begin
      checkOutput("start busy", {31'd0, busy}, 32'd1);
      checkOutput("start address", {24'd0, ram_addr}, {24'd0, base});
    end
  endtask

  // Feed len rx pulses; gap<0 picks random gaps, stray start_rd pulses must be ignored
  task automatic writeBytes(input logic [7:0] len, input int gap);
    int g;
    @(posedge clk); #1;
    for (int i = 0; i < int'(len); i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      if (g > 0) begin
        rx_flag = 1'b0;
        repeat (g) begin
          start_rd = ($urandom_range(0, 3) == 0);
          @(posedge clk); #1;
        end
      end
      start_rd = 1'b0;
      rx_flag  = 1'b1;
      @(posedge clk); #1;
    end
    rx_flag = 1'b0;
    @(negedge clk);
    checkOutput("write done", {31'd0, done}, 32'd1);
    checkOutput("write count", {24'd0, xfer_cnt}, {24'd0, len});
    checkOutput("write busy end", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  // Wait (bounded) for the done of a read transfer
  task automatic waitReadDone(input logic [7:0] len);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput("read done seen", {31'd0, seen}, 32'd1);
    checkOutput("read count", {24'd0, xfer_cnt}, {24'd0, len});
    @(posedge clk); #1;
  endtask

  task automatic doXfer(input logic wr, input logic [7:0] base, input logic [7:0] len, input int gap);
    pushXfer(wr, base, len);
    applyStimulus(wr, !wr, base, len);
    if (len == 8'd0) begin
      @(posedge clk); #1;
    end else if (wr) begin
      writeBytes(len, gap);
    end else begin
      waitReadDone(len);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int trigCount;
    rst_n = 1'b1;
    start_wr = 1'b0;
    start_rd = 1'b0;
    abort = 1'b0;
    length = 8'd0;
    base_addr = 8'd0;
    rx_flag = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset ram_addr", {24'd0, ram_addr}, 32'd0);
    checkOutput("reset ram_we", {31'd0, ram_we}, 32'd0);
    checkOutput("reset tx_trig", {31'd0, tx_trig}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset xfer_cnt", {24'd0, xfer_cnt}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] write base 0x10 length 4");
    doXfer(1'b1, 8'h10, 8'd4, 2);

    $display("[TB] read base 0xFE length 3 with wrap");
    txBusyCycles = 10;
    doXfer(1'b0, 8'hFE, 8'd3, 0);

    $display("[TB] zero-length read");
    doXfer(1'b0, 8'h40, 8'd0, 0);

    $display("[TB] simultaneous starts, write wins");
    pushXfer(1'b1, 8'h80, 8'd2);
    applyStimulus(1'b1, 1'b1, 8'h80, 8'd2);
    writeBytes(8'd2, 0);

    $display("[TB] abort in RD_ACK of second byte");
    txBusyCycles = 6;
    pushEv(EV_TRIG, 8'h20);
    pushEv(EV_TRIG, 8'h21);
    applyStimulus(1'b0, 1'b1, 8'h20, 8'd5);
    trigCount = 0;
    for (int k = 0; k < 200 && trigCount < 2; k++) begin
      @(negedge clk);
      if (tx_trig) trigCount++;
    end
    checkOutput("abort trigger count", 32'(trigCount), 32'd2);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort done", {31'd0, done}, 32'd0);
    checkOutput("abort count", {24'd0, xfer_cnt}, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    doXfer(1'b0, 8'h30, 8'd2, 0);

    $display("[TB] reset in the middle of a write");
    pushEv(EV_WE, 8'h55);
    pushEv(EV_WE, 8'h56);
    applyStimulus(1'b1, 1'b0, 8'h55, 8'd4);
    @(posedge clk); #1;
    rx_flag = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rx_flag = 1'b0;
    #2 rst_n = 1'b0;
    rx_flag = 1'b1;
    #1;
    checkOutput("async reset ram_we", {31'd0, ram_we}, 32'd0);
    checkOutput("async reset busy", {31'd0, busy}, 32'd0);
    checkOutput("async reset ram_addr", {24'd0, ram_addr}, 32'd0);
    checkOutput("async reset xfer_cnt", {24'd0, xfer_cnt}, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("no write after reset", {31'd0, ram_we}, 32'd0);
    end
    @(posedge clk); #1;
    rx_flag = 1'b0;
    @(posedge clk); #1;

    $display("[TB] randomized transfers");
    for (int n = 0; n < 24; n++) begin
      txBusyCycles = int'($urandom_range(1, 6));
      doXfer(($urandom_range(0, 1) == 1), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 6)), -1);
    end

    repeat (3) @(posedge clk);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
